// File: rtl/fu_divsqrt_pkg.sv
// rtl/fu_divsqrt_pkg.sv - shared state encoding and default width for the div/sqrt on-the-fly converter
package fu_divsqrt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10,
    S_DONE = 2'b11
  } otf_state_t;

  localparam int QW_DEFAULT = 57;

endpackage

// File: rtl/fu_divsqrt_otf_conv_if.sv
// rtl/fu_divsqrt_otf_conv_if.sv - control/digit/result bundle for fu_divsqrt_otf_conv; dig_err only with FU_DIVSQRT_OTF_CHK_EN
interface fu_divsqrt_otf_conv_if
  import fu_divsqrt_pkg::*;
#(
  parameter int QW = QW_DEFAULT
);

  logic          start;
  logic          flush;
  logic          dig_val;
  logic          pq;
  logic          nq;
  logic          rem_val;
  logic          rem_neg;
  logic          res_ack;
  logic          busy;
  logic          dig_rdy;
  logic          res_val;
  logic [0:QW-1] q_out;
`ifdef FU_DIVSQRT_OTF_CHK_EN
  logic          dig_err;

  modport master (
    output start, flush, dig_val, pq, nq, rem_val, rem_neg, res_ack,
    input  busy, dig_rdy, res_val, q_out, dig_err
  );
  modport slave (
    input  start, flush, dig_val, pq, nq, rem_val, rem_neg, res_ack,
    output busy, dig_rdy, res_val, q_out, dig_err
  );
`else
  modport master (
    output start, flush, dig_val, pq, nq, rem_val, rem_neg, res_ack,
    input  busy, dig_rdy, res_val, q_out
  );
  modport slave (
    input  start, flush, dig_val, pq, nq, rem_val, rem_neg, res_ack,
    output busy, dig_rdy, res_val, q_out
  );
`endif

endinterface

// File: rtl/fu_divsqrt_otf_sel.sv
// rtl/fu_divsqrt_otf_sel.sv - combinational Q/QM next-value select for one signed quotient digit
module fu_divsqrt_otf_sel
  import fu_divsqrt_pkg::*;
#(
  parameter int QW = QW_DEFAULT
) (
  input  logic [0:QW-1] q,
  input  logic [0:QW-1] qm,
  input  logic          pq,
  input  logic          nq,
  output logic [0:QW-1] q_nxt,
  output logic [0:QW-1] qm_nxt
);

  // The MSBs shift out; the conversion only needs the low QW-1 bits of each register.
  logic unused_msb;
  assign unused_msb = q[0] ^ qm[0];

  // pq and nq both set falls through to the zero-digit case.
  always_comb begin
    q_nxt  = {q[1:QW-1], 1'b0};
    qm_nxt = {qm[1:QW-1], 1'b1};
    if (pq && !nq) begin
      q_nxt  = {q[1:QW-1], 1'b1};
      qm_nxt = {q[1:QW-1], 1'b0};
    end else if (nq && !pq) begin
      q_nxt  = {qm[1:QW-1], 1'b1};
      qm_nxt = {qm[1:QW-1], 1'b0};
    end
  end

endmodule

// File: rtl/fu_divsqrt_otf_conv.sv
// rtl/fu_divsqrt_otf_conv.sv - on-the-fly signed-digit to binary quotient converter; FU_DIVSQRT_OTF_CHK_EN adds a sticky dig_err
module fu_divsqrt_otf_conv
  import fu_divsqrt_pkg::*;
#(
  parameter int QW = QW_DEFAULT
) (
  input  logic                  nclk,
  input  logic                  rst,
  fu_divsqrt_otf_conv_if.slave  bus
);

  localparam int CW = $clog2(QW + 1);
  localparam logic [CW-1:0] LAST = CW'(QW - 1);

  otf_state_t    state;
  logic [0:QW-1] q, qm, q_nxt, qm_nxt, q_res;
  logic [CW-1:0] cnt;
  logic          dig_take;

  fu_divsqrt_otf_sel #(.QW(QW)) u_sel (
    .q      (q),
    .qm     (qm),
    .pq     (bus.pq),
    .nq     (bus.nq),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt)
  );

  assign dig_take    = (state == S_RUN) && bus.dig_val && !bus.flush;
  assign bus.busy    = (state != S_IDLE);
  assign bus.dig_rdy = (state == S_RUN);
  assign bus.res_val = (state == S_DONE);
  assign bus.q_out   = q_res;

  // flush only redirects the state; Q, QM and the last result are kept.
  always_ff @(posedge nclk) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      qm    <= '0;
      cnt   <= '0;
      q_res <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_RUN;
          q     <= '0;
          qm    <= '1;
          cnt   <= '0;
        end
        S_RUN: if (bus.dig_val) begin
          q   <= q_nxt;
          qm  <= qm_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= S_FIN;
        end
        S_FIN: if (bus.rem_val) begin
          q_res <= bus.rem_neg ? qm : q;
          state <= S_DONE;
        end
        S_DONE: if (bus.res_ack) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FU_DIVSQRT_OTF_CHK_EN
  logic err;
  assign bus.dig_err = err;

  always_ff @(posedge nclk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == S_IDLE && bus.start && !bus.flush) begin
      err <= 1'b0;
    end else if (dig_take && bus.pq && bus.nq) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fu_divsqrt_otf_conv.sv
// tb/tb_fu_divsqrt_otf_conv.sv - directed and random checks of fu_divsqrt_otf_conv at QW=4 against an arithmetic quotient model
module tb_fu_divsqrt_otf_conv;

  logic nclk = 1'b0;
  logic rst;
  int   total = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   dq[$];
  logic [3:0] exp_q;

  fu_divsqrt_otf_conv_if #(.QW(4)) bus ();

  fu_divsqrt_otf_conv #(.QW(4)) dut (
    .nclk (nclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 nclk = ~nclk;

  task automatic step();
    @(posedge nclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Quotient as plain arithmetic: sum of d_i * 2^(QW-1-i), minus one ulp if the remainder is negative, mod 2^QW.
  function automatic logic [3:0] model(input int digs[$], input bit neg);
    int v;
    v = 0;
    foreach (digs[i]) v = 2 * v + ((digs[i] == 2) ? 0 : digs[i]);
    if (neg) v = v - 1;
    return 4'(v);
  endfunction

  task automatic start_op();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("start_busy", 32'(bus.busy), 1);
    check("start_rdy", 32'(bus.dig_rdy), 1);
  endtask

  // Digit codes: 1 = +1, -1 = -1, 0 = zero, 2 = pq and nq both set.
  task automatic feed(input int d, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.dig_val = 1'b0;
        bus.pq = $urandom_range(0, 1) != 0;
        bus.nq = $urandom_range(0, 1) != 0;
        step();
      end
    end
    bus.dig_val = 1'b1;
    bus.pq = (d == 1) || (d == 2);
    bus.nq = (d == -1) || (d == 2);
    step();
    bus.dig_val = 1'b0;
    bus.pq = 1'b0;
    bus.nq = 1'b0;
  endtask

  task automatic finish_op(input bit neg, input logic [3:0] exp, input bit stray);
    check("fin_rdy", 32'(bus.dig_rdy), 0);
    check("fin_busy", 32'(bus.busy), 1);
    if (stray) begin
      bus.dig_val = 1'b1;
      bus.pq = 1'b1;
      step();
      bus.dig_val = 1'b0;
      bus.pq = 1'b0;
    end
    check("fin_res", 32'(bus.res_val), 0);
    bus.rem_val = 1'b1;
    bus.rem_neg = neg;
    step();
    bus.rem_val = 1'b0;
    bus.rem_neg = 1'b0;
    check("res_val", 32'(bus.res_val), 1);
    check("q_out", 32'(bus.q_out), 32'(exp));
  endtask

  task automatic run_op(input int digs[$], input bit neg, input bit gaps, input bit stray);
    start_op();
    foreach (digs[i]) feed(digs[i], gaps);
    finish_op(neg, model(digs, neg), stray);
  endtask

  task automatic ack();
    bus.res_ack = 1'b1;
    step();
    bus.res_ack = 1'b0;
    check("ack_busy", 32'(bus.busy), 0);
    check("ack_res", 32'(bus.res_val), 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.dig_val = 1'b0; bus.pq = 1'b0; bus.nq = 1'b0;
    bus.rem_val = 1'b0; bus.rem_neg = 1'b0; bus.res_ack = 1'b0;
    step();
    bus.start = 1'b1;
    step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_rdy", 32'(bus.dig_rdy), 0);
    check("rst_res", 32'(bus.res_val), 0);
    check("rst_q", 32'(bus.q_out), 0);
`ifdef FU_DIVSQRT_OTF_CHK_EN
    check("rst_err", 32'(bus.dig_err), 0);
`endif

    // Start in the very cycle reset drops, then the reference digit strings.
    rst = 1'b0;
    dq = {1, 0, -1, 1};
    run_op(dq, 1'b0, 1'b0, 1'b0);
    check("ex_pos", 32'(bus.q_out), 32'h7);
    ack();
    run_op(dq, 1'b1, 1'b0, 1'b0);
    check("ex_neg", 32'(bus.q_out), 32'h6);
    ack();

    // Flush after the second digit, start in the same cycle.
    start_op();
    feed(1, 1'b0);
    feed(-1, 1'b0);
    bus.flush = 1'b1; bus.start = 1'b1; bus.dig_val = 1'b1; bus.pq = 1'b1;
    step();
    bus.flush = 1'b0; bus.start = 1'b0; bus.dig_val = 1'b0; bus.pq = 1'b0;
    check("flush_busy", 32'(bus.busy), 0);
    check("flush_rdy", 32'(bus.dig_rdy), 0);
    check("flush_q", 32'(bus.q_out), 32'h6);
    dq = {-1, -1, -1, -1};
    run_op(dq, 1'b0, 1'b0, 1'b1);
    check("m1_pos", 32'(bus.q_out), 32'h1);
    ack();
    run_op(dq, 1'b1, 1'b0, 1'b0);
    check("m1_neg", 32'(bus.q_out), 32'h0);
    ack();

    // Digit, remainder and ack strobes in IDLE do nothing.
    bus.dig_val = 1'b1; bus.pq = 1'b1; bus.rem_val = 1'b1; bus.rem_neg = 1'b1; bus.res_ack = 1'b1;
    step();
    bus.dig_val = 1'b0; bus.pq = 1'b0; bus.rem_val = 1'b0; bus.rem_neg = 1'b0; bus.res_ack = 1'b0;
    check("idle_busy", 32'(bus.busy), 0);
    check("idle_q", 32'(bus.q_out), 32'h0);

    // Withhold res_ack in DONE while start is toggled.
    dq = {1, 1, 0, -1};
    exp_q = model(dq, 1'b0);
    run_op(dq, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      bus.start = c[0];
      step();
      check("hold_res", 32'(bus.res_val), 1);
      check("hold_q", 32'(bus.q_out), 32'(exp_q));
    end
    bus.start = 1'b1;
    ack();
    bus.start = 1'b0;
    step();
    check("ack_start_ign", 32'(bus.busy), 0);

    // Random digit strings with idle gaps.
    for (int k = 0; k < 10; k++) begin
      bit neg;
      dq = {};
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 3))
          0: dq.push_back(0);
          1: dq.push_back(1);
          2: dq.push_back(-1);
          default: dq.push_back(2);
        endcase
      end
      neg = $urandom_range(0, 1) != 0;
      run_op(dq, neg, 1'b1, k[0]);
      ack();
    end

    // Reset in the middle of an operation.
    dq = {1, 0, -1, 1};
    run_op(dq, 1'b0, 1'b0, 1'b0);
    ack();
    start_op();
    feed(1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_rdy", 32'(bus.dig_rdy), 0);
    check("mid_rst_res", 32'(bus.res_val), 0);
    check("mid_rst_q", 32'(bus.q_out), 0);

`ifdef FU_DIVSQRT_OTF_CHK_EN
    start_op();
    check("err_clr", 32'(bus.dig_err), 0);
    feed(1, 1'b0);
    feed(2, 1'b0);
    check("err_set", 32'(bus.dig_err), 1);
    feed(-1, 1'b0);
    feed(0, 1'b0);
    check("err_sticky", 32'(bus.dig_err), 1);
    dq = {1, 2, -1, 0};
    finish_op(1'b0, model(dq, 1'b0), 1'b0);
    check("err_done", 32'(bus.dig_err), 1);
    ack();
    check("err_idle", 32'(bus.dig_err), 1);
    start_op();
    check("err_restart", 32'(bus.dig_err), 0);
    feed(2, 1'b0);
    check("err_set2", 32'(bus.dig_err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_rst", 32'(bus.dig_err), 0);
    check("err_rst_busy", 32'(bus.busy), 0);
    check("err_rst_q", 32'(bus.q_out), 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
